// File: rtl/id_issue_ctrl.sv
// Single-slot issue controller between ID and EX: decodes the held instruction,
// checks it against the register scoreboard and releases it once it is hazard-free.
module id_issue_ctrl #(
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        instruction,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic [1:0]         out_type,
    input  logic               wb_valid,
    input  logic [4:0]         wb_rd,
    input  logic               flush,
    output logic [31:0]        pending,
    output logic               halted,
    output logic [STALL_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    localparam logic [1:0] TYPE_R    = 2'd0;
    localparam logic [1:0] TYPE_J    = 2'd1;
    localparam logic [1:0] TYPE_HALT = 2'd2;
    localparam logic [1:0] TYPE_I    = 2'd3;

    localparam logic [5:0] OP_HALT = 6'h3f;

    state_t      state;
    state_t      state_next;
    logic        slot_valid;
    logic [31:0] slot_instr;
    logic [31:0] pending_next;

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        use_rs;
    logic        use_rt;
    logic        dst_en;
    logic [4:0]  dst;
    logic        is_halt;
    logic        hazard;
    logic        issue;
    logic        capture;
    logic        stall_inc;

    assign opcode = slot_instr[31:26];
    assign rs     = slot_instr[25:21];
    assign rt     = slot_instr[20:16];
    assign rd     = slot_instr[15:11];

    always_comb begin
        out_type = TYPE_I;
        use_rs   = 1'b0;
        use_rt   = 1'b0;
        dst_en   = 1'b0;
        dst      = rt;
        is_halt  = 1'b0;
        case (opcode)
            6'h00: begin
                out_type = TYPE_R;
                use_rs   = 1'b1;
                use_rt   = 1'b1;
                dst_en   = 1'b1;
                dst      = rd;
            end
            6'h02: out_type = TYPE_J;
            OP_HALT: begin
                out_type = TYPE_HALT;
                is_halt  = 1'b1;
            end
            // Store and branches read rt rather than writing it.
            6'h2b, 6'h04, 6'h05: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            default: begin
                use_rs = 1'b1;
                dst_en = 1'b1;
            end
        endcase
    end

    // r0 is hard-wired zero, so it can never be the cause of a stall.
    assign hazard = is_halt ? (|pending)
                  : ((use_rs && rs != 5'd0 && pending[rs]) ||
                     (use_rt && rt != 5'd0 && pending[rt]) ||
                     (dst_en && dst != 5'd0 && pending[dst]));

    assign out_valid = !rst && slot_valid && !hazard && !flush && (state != ST_HALTED);
    assign issue     = out_valid && out_ready;
    assign in_ready  = !rst && (state == ST_RUN) && !flush && (!slot_valid || issue);
    assign capture   = in_valid && in_ready;
    assign stall_inc = slot_valid && !issue && (state != ST_HALTED);

    assign out_instr = slot_instr;
    assign halted    = (state == ST_HALTED);

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:    if (capture && instruction[31:26] == OP_HALT) state_next = ST_DRAIN;
            ST_DRAIN:  if (flush) state_next = ST_RUN;
                       else if (issue) state_next = ST_HALTED;
            ST_HALTED: state_next = ST_HALTED;
            default:   state_next = ST_RUN;
        endcase
    end

    // Retirement is applied before the new claim so a same-register collision stays set.
    always_comb begin
        pending_next = pending;
        if (wb_valid) pending_next[wb_rd] = 1'b0;
        if (issue && dst_en && dst != 5'd0) pending_next[dst] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            slot_valid  <= 1'b0;
            slot_instr  <= 32'd0;
            pending     <= 32'd0;
            stall_count <= '0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            if (stall_inc && stall_count != {STALL_W{1'b1}})
                stall_count <= stall_count + 1'b1;
            if (flush && state != ST_HALTED) begin
                slot_valid <= 1'b0;
            end else if (capture) begin
                slot_valid <= 1'b1;
                slot_instr <= instruction;
            end else if (issue) begin
                slot_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Randomized and directed bench for id_issue_ctrl, compared every cycle against
// an instruction-level reference model of the issue slot and scoreboard.
module tb_id_issue_ctrl;

    localparam int SW        = 4;
    localparam int STALL_MAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   instruction = 32'd0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_instr;
    logic [1:0]    out_type;
    logic          wb_valid = 1'b0;
    logic [4:0]    wb_rd = 5'd0;
    logic          flush = 1'b0;
    logic [31:0]   pending;
    logic          halted;
    logic [SW-1:0] stall_count;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit          m_slot;
    logic [31:0] m_instr;
    bit          m_pend[32];
    bit          m_drain;
    bit          m_halted;
    int          m_stall;

    id_issue_ctrl #(.STALL_W(SW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_type(out_type), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .flush(flush), .pending(pending), .halted(halted),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // kind: 0=R 1=J 2=HALT 3=I; register numbers are -1 when unused
    function automatic void classify(input logic [31:0] w, output int kind,
                                     output int src1, output int src2, output int dst);
        int op;
        op   = int'(w[31:26]);
        src1 = -1;
        src2 = -1;
        dst  = -1;
        if (op == 0) begin
            kind = 0; src1 = int'(w[25:21]); src2 = int'(w[20:16]); dst = int'(w[15:11]);
        end else if (op == 2) begin
            kind = 1;
        end else if (op == 63) begin
            kind = 2;
        end else begin
            kind = 3;
            src1 = int'(w[25:21]);
            if (op == 43 || op == 4 || op == 5) src2 = int'(w[20:16]);
            else dst = int'(w[20:16]);
        end
    endfunction

    function automatic bit reg_busy(input int r);
        return (r > 0) && m_pend[r];
    endfunction

    function automatic bit any_pending();
        for (int i = 0; i < 32; i++) if (m_pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] r_ins(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
        return {6'h00, s, t, d, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                                          input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    localparam logic [31:0] HALT_INS = {6'h3f, 26'd0};
    localparam logic [31:0] J_INS    = {6'h02, 26'h0000123};

    task automatic model_reset();
        m_slot = 0; m_instr = 32'd0; m_drain = 0; m_halted = 0; m_stall = 0;
        for (int i = 0; i < 32; i++) m_pend[i] = 0;
    endtask

    // One full clock cycle: drive, check combinational and state outputs, advance model.
    task automatic applyStimulus(input bit iv, input logic [31:0] ins, input bit ordy,
                                 input bit wbv, input logic [4:0] wbr, input bit fl, input bit r);
        int kind, s1, s2, d;
        bit blocked, e_ov, e_issue, e_ir;
        logic [31:0] e_pend;
        @(negedge clk);
        in_valid = iv; instruction = ins; out_ready = ordy;
        wb_valid = wbv; wb_rd = wbr; flush = fl; rst = r;
        #1;
        classify(m_instr, kind, s1, s2, d);
        blocked = (kind == 2) ? any_pending() : (reg_busy(s1) || reg_busy(s2) || reg_busy(d));
        e_ov    = !r && m_slot && !blocked && !fl && !m_halted;
        e_issue = e_ov && ordy;
        e_ir    = !r && !m_drain && !m_halted && !fl && (!m_slot || e_issue);
        for (int i = 0; i < 32; i++) e_pend[i] = m_pend[i];
        checkOutput("out_valid",   32'(out_valid),   32'(e_ov));
        checkOutput("in_ready",    32'(in_ready),    32'(e_ir));
        checkOutput("out_instr",   out_instr,        m_instr);
        checkOutput("out_type",    32'(out_type),    32'(kind));
        checkOutput("pending",     pending,          e_pend);
        checkOutput("halted",      32'(halted),      32'(m_halted));
        checkOutput("stall_count", 32'(stall_count), 32'(m_stall));
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (m_slot && !e_issue && !m_halted && m_stall < STALL_MAX) m_stall++;
            if (wbv) m_pend[wbr] = 0;
            if (e_issue && d > 0) m_pend[d] = 1;
            if (e_issue && kind == 2) begin
                m_halted = 1; m_drain = 0;
            end
            if (fl && m_drain) m_drain = 0;
            if (fl && !m_halted) m_slot = 0;
            else if (iv && e_ir) begin
                m_slot = 1; m_instr = ins;
                if (ins[31:26] == 6'h3f) m_drain = 1;
            end else if (e_issue) m_slot = 0;
        end
    endtask

    task automatic idle(input bit ordy, input bit wbv, input logic [4:0] wbr);
        applyStimulus(1'b0, 32'd0, ordy, wbv, wbr, 1'b0, 1'b0);
    endtask

    task automatic reset_cycle();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    endtask

    function automatic logic [31:0] rand_ins();
        logic [5:0] ops[8];
        logic [5:0] op;
        ops[0] = 6'h00; ops[1] = 6'h02; ops[2] = 6'h2b; ops[3] = 6'h04;
        ops[4] = 6'h05; ops[5] = 6'h08; ops[6] = 6'h23; ops[7] = 6'h00;
        op = ($urandom_range(0, 15) == 0) ? 6'h3f : ops[$urandom_range(0, 7)];
        return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 11'($urandom)};
    endfunction

    initial begin
        model_reset();

        // RAW on r3, released one cycle after its writeback
        reset_cycle();
        applyStimulus(1, r_ins(5'd1, 5'd2, 5'd3), 1, 0, 5'd0, 0, 0);
        applyStimulus(1, r_ins(5'd3, 5'd0, 5'd0), 1, 0, 5'd0, 0, 0);
        repeat (3) idle(1, 0, 5'd0);
        idle(1, 1, 5'd3);
        idle(1, 0, 5'd0);
        #2;
        checkOutput("raw_pending", pending, 32'h0);
        checkOutput("raw_stall", 32'(stall_count), 32'd4);

        // r0 destination and source never stall
        reset_cycle();
        applyStimulus(1, r_ins(5'd1, 5'd2, 5'd0), 1, 0, 5'd0, 0, 0);
        applyStimulus(1, r_ins(5'd0, 5'd0, 5'd0), 1, 0, 5'd0, 0, 0);
        idle(1, 0, 5'd0);
        #2;
        checkOutput("r0_pending", pending, 32'h0);
        checkOutput("r0_stall", 32'(stall_count), 32'd0);

        // Store waits on rt and claims nothing; addi claims rt
        reset_cycle();
        applyStimulus(1, i_ins(6'h08, 5'd0, 5'd5, 16'd1), 1, 0, 5'd0, 0, 0);
        applyStimulus(1, i_ins(6'h2b, 5'd4, 5'd5, 16'd0), 1, 0, 5'd0, 0, 0);
        idle(1, 0, 5'd0);
        idle(1, 1, 5'd5);
        idle(1, 0, 5'd0);
        #2;
        checkOutput("store_pending", pending, 32'h0);
        applyStimulus(1, i_ins(6'h08, 5'd0, 5'd6, 16'd2), 1, 0, 5'd0, 0, 0);
        idle(1, 0, 5'd0);
        #2;
        checkOutput("addi_pending", pending, 32'h40);

        // HALT drains r7, then parks
        reset_cycle();
        applyStimulus(1, i_ins(6'h08, 5'd0, 5'd7, 16'd1), 1, 0, 5'd0, 0, 0);
        applyStimulus(1, HALT_INS, 1, 0, 5'd0, 0, 0);
        applyStimulus(1, r_ins(5'd1, 5'd1, 5'd1), 1, 0, 5'd0, 0, 0);
        applyStimulus(1, r_ins(5'd1, 5'd1, 5'd1), 1, 1, 5'd7, 0, 0);
        #2;
        checkOutput("halt_not_yet", 32'(halted), 32'd0);
        applyStimulus(1, r_ins(5'd1, 5'd1, 5'd1), 1, 0, 5'd0, 0, 0);
        #2;
        checkOutput("halt_raised", 32'(halted), 32'd1);
        repeat (3) applyStimulus(1, r_ins(5'd2, 5'd2, 5'd2), 1, 0, 5'd0, 1, 0);
        #2;
        checkOutput("halt_pending", pending, 32'h0);

        // Reset in the middle of a drain
        reset_cycle();
        applyStimulus(1, i_ins(6'h08, 5'd0, 5'd8, 16'd0), 1, 0, 5'd0, 0, 0);
        applyStimulus(1, HALT_INS, 1, 0, 5'd0, 0, 0);
        idle(1, 0, 5'd0);
        #2;
        checkOutput("drain_pending", pending, 32'h100);
        reset_cycle();
        #2;
        checkOutput("rst_pending", pending, 32'h0);
        checkOutput("rst_out_instr", out_instr, 32'h0);
        checkOutput("rst_stall", 32'(stall_count), 32'd0);
        applyStimulus(1, r_ins(5'd1, 5'd2, 5'd3), 1, 0, 5'd0, 0, 0);
        idle(1, 0, 5'd0);

        // Flush of a slot stalled on r8
        reset_cycle();
        applyStimulus(1, i_ins(6'h08, 5'd0, 5'd8, 16'd0), 1, 0, 5'd0, 0, 0);
        applyStimulus(1, r_ins(5'd8, 5'd1, 5'd2), 1, 0, 5'd0, 0, 0);
        idle(1, 0, 5'd0);
        applyStimulus(1, r_ins(5'd1, 5'd1, 5'd1), 1, 0, 5'd0, 1, 0);
        #2;
        checkOutput("flush_pending", pending, 32'h100);
        applyStimulus(1, r_ins(5'd1, 5'd1, 5'd9), 1, 0, 5'd0, 0, 0);
        idle(1, 0, 5'd0);

        // Back-pressure and stall counter saturation
        reset_cycle();
        applyStimulus(1, J_INS, 0, 0, 5'd0, 0, 0);
        repeat (5) idle(0, 0, 5'd0);
        #2;
        checkOutput("bp_stall5", 32'(stall_count), 32'd5);
        repeat (12) idle(0, 0, 5'd0);
        #2;
        checkOutput("bp_saturate", 32'(stall_count), 32'(STALL_MAX));
        idle(1, 0, 5'd0);

        // Randomized traffic
        reset_cycle();
        for (int n = 0; n < 1500; n++) begin
            bit r;
            r = ($urandom_range(0, 99) == 0) || (m_halted && $urandom_range(0, 3) == 0);
            applyStimulus($urandom_range(0, 9) < 7, rand_ins(), $urandom_range(0, 3) != 0,
                          $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
                          $urandom_range(0, 19) == 0, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_issue_ctrl.md
# id_issue_ctrl

Issue controller between the ID stage and EX of the MIPS-32 pipeline. It holds one fetched instruction in a single-entry issue slot and classifies it R/J/HALT/I from the opcode. A 32-bit register scoreboard tracks outstanding register-file writes. The instruction is released to EX only once all of its source and destination registers are free. A HALT drains the pipeline and then parks the controller until reset.

## Interface
Parameters:
- `STALL_W`, default 16: width of the saturating stall counter.

Ports:
- `clk`, input, 1: pipeline clock. All state updates on its rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `in_valid`, input, 1: IF is presenting `instruction`.
- `in_ready`, output, 1: the slot accepts `instruction` this cycle.
- `instruction`, input, 32: the fetched instruction word.
- `out_valid`, output, 1: the slot instruction is issuing to EX.
- `out_ready`, input, 1: EX accepts the instruction.
- `out_instr`, output, 32: the slot instruction word.
- `out_type`, output, 2: the slot instruction class. R=0, J=1, HALT=2, I=3.
- `wb_valid`, input, 1: writeback retires a register write this cycle.
- `wb_rd`, input, 5: the register being retired.
- `flush`, input, 1: discards the slot contents (redirect).
- `pending`, output, 32: scoreboard; bit n=1 means a write to rn is outstanding.
- `halted`, output, 1: the controller is in the HALTED state.
- `stall_count`, output, `STALL_W`: number of cycles in which the slot was occupied but did not issue.

## Operation
Decode of the slot contents (opcode = `instr[31:26]`):
- **R-type** (opcode 000000): sources rs, rt; destination rd.
- **J-type** (opcode 000010): no sources, no destination.
- **HALT** (opcode 111111): no sources, no destination.
- **I-type** (all other opcodes): source rs.
  - Opcodes 101011, 000100, 000101 additionally use rt as a source and have no destination.
  - All other I-type opcodes use rt as the destination.
- Register r0 never causes a hazard and is never set in the scoreboard.

Hazard condition: any used source or destination register has its `pending` bit set. This covers both RAW and WAW. HALT has a hazard whenever `pending` is non-zero.

State machine:
- **RUN → DRAIN**: when HALT is captured into the slot.
- **DRAIN → HALTED**: when HALT issues.
- **DRAIN → RUN**: on `flush`.
- **HALTED**: left only by `rst`.

Output and update rules:
- `out_valid` = slot_valid & !hazard & !flush & state≠HALTED.
- issue = `out_valid` & `out_ready`.
- `in_ready` = (state==RUN) & !flush & (!slot_valid | issue).
- Capture: when `in_valid` & `in_ready`, the slot loads `instruction` and slot_valid goes to 1. Otherwise, issue clears slot_valid.
- Scoreboard update, applied in this order:
  - first, `wb_valid` clears bit `wb_rd`;
  - then, issue sets the destination bit.
  - If both name the same register in the same cycle, the bit ends up set.
- `flush`: clears slot_valid and issues nothing. The scoreboard is unaffected (in-flight writes still retire). `flush` is ignored in HALTED.
- `stall_count`: increments when slot_valid & !issue & state≠HALTED. It saturates at all-ones.
- `out_instr`/`out_type` reflect the slot even when `out_valid`=0.

## Timing
- Reset values:
  - `in_ready`=0 during reset; it is evaluated from the reset state on the following cycle.
  - slot_valid=0, `out_valid`=0, `out_instr`=0, `out_type`=0.
  - `pending`=0, `halted`=0, `stall_count`=0, state=RUN.
- Capture-to-issue latency: an instruction captured at edge N can issue in cycle N+1 if it has no hazard.
- There is no writeback bypass. A `wb_valid` in cycle N clears its bit at edge N+1, so a dependent instruction issues in cycle N+1 at the earliest.
- Back-to-back throughput is 1/cycle: capture and issue happen in the same cycle when `out_ready`=1.
- `halted` rises at the edge following the HALT issue.
- `rst` during DRAIN or mid-stall discards the slot and the scoreboard immediately.

## Test plan
- **RAW**: issue R `add` with rd=3. The next instruction is R with rs=3. Required: `out_valid`=0 and `stall_count` increments until `wb_valid`=1 with `wb_rd`=3; the dependent instruction issues exactly one cycle later and `pending[3]` ends at 0.
- **r0 destination**: issue R with rd=0, then R with rs=0. Required: `pending` stays 0 and both instructions issue on consecutive cycles.
- **I-type store**: opcode 101011 with rs=4, rt=5 while `pending[5]`=1. Required: stall until r5 retires, and no scoreboard bit is set on issue. Compare opcode 001000 with rt=6: `pending[6]` is set on issue.
- **HALT**: HALT captured while `pending[7]`=1. Required: `in_ready`=0 (DRAIN); HALT issues in the cycle after `wb_rd`=7 retires; `halted`=1 at the next edge; further `in_valid` is ignored.
- **Flush and back-pressure**: slot stalled on r8, then `flush`=1. Required: slot emptied, no issue, `pending[8]` still 1, `in_ready`=1 the next cycle. Separately, hold `out_ready`=0 with a hazard-free slot for 5 cycles: required `stall_count`=5.
- **Reset mid-drain**: assert `rst` in DRAIN with `pending`=0x0000_0100. Required: all outputs return to their reset values and the controller accepts a new instruction after reset deasserts.
